// File: rtl/program_loader.sv
// -----------------------------------------------------------------------------
// program_loader
//   Boot instruction store for the CPU. A program image arrives as a byte
//   stream (valid/ready) in the form
//     LEN_HI LEN_LO { WORD_HI WORD_LO } x N  CHECKSUM
//   where CHECKSUM is the XOR of every preceding image byte. Words land in the
//   internal store as they arrive; the CPU is held in reset until the checksum
//   matches, after which PC/IR serve instruction fetches.
//
// Ports
//   clk          system clock, rising edge
//   reset        synchronous active-high reset
//   rxData       image byte
//   rxValid      rxData holds a byte
//   rxReady      loader accepts a byte this cycle (state-only decode)
//   reload       one-cycle pulse; restarts loading from RUN or ERROR
//   PC           fetch address (low ADDR_WIDTH bits used, wraps)
//   IR           instruction word at PC while in RUN, else 0
//   cpuReset     CPU reset, high whenever not in RUN
//   loadDone     high in RUN
//   loadError    high in ERROR
//   wordsLoaded  words written during the current load
// -----------------------------------------------------------------------------
module program_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int BUS_SIZE   = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          rxData,
    input  logic                rxValid,
    output logic                rxReady,
    input  logic                reload,
    input  logic [BUS_SIZE-1:0] PC,
    output logic [BUS_SIZE-1:0] IR,
    output logic                cpuReset,
    output logic                loadDone,
    output logic                loadError,
    output logic [15:0]         wordsLoaded
);

    localparam int          DEPTH   = 1 << ADDR_WIDTH;
    // 17 bits so a full 16-bit address space (DEPTH = 65536) still compares.
    localparam logic [16:0] DEPTH_L = 17'(DEPTH);

    typedef enum logic [2:0] {
        S_LEN_HI,
        S_LEN_LO,
        S_DATA_HI,
        S_DATA_LO,
        S_CHECK,
        S_RUN,
        S_ERROR
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   len_q, len_d;
    logic [7:0]    xor_q, xor_d;
    logic [7:0]    stage_q, stage_d;
    logic [15:0]   words_q, words_d;
    logic          cpu_reset_q, done_q, error_q;

    logic          accept;
    logic          mem_we;
    logic [15:0]   len_new;

    logic [BUS_SIZE-1:0] mem [DEPTH];

    // Upper PC bits are intentionally ignored (fetches wrap modulo DEPTH).
    logic unused_pc;
    assign unused_pc = ^PC;

    // Ready depends on state only, so the source never sees a comb loop.
    always_comb begin
        rxReady = 1'b0;
        case (state_q)
            S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHECK: rxReady = 1'b1;
            default:                                           rxReady = 1'b0;
        endcase
    end

    assign accept  = rxValid && rxReady;
    assign len_new = {len_q[15:8], rxData};

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        xor_d   = xor_q;
        stage_d = stage_q;
        words_d = words_q;
        mem_we  = 1'b0;

        case (state_q)
            S_LEN_HI: begin
                if (accept) begin
                    len_d[15:8] = rxData;
                    xor_d       = xor_q ^ rxData;
                    state_d     = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (accept) begin
                    len_d = len_new;
                    xor_d = xor_q ^ rxData;
                    if ({1'b0, len_new} > DEPTH_L)
                        state_d = S_ERROR;
                    else if (len_new == 16'd0)
                        state_d = S_CHECK;
                    else
                        state_d = S_DATA_HI;
                end
            end
            S_DATA_HI: begin
                if (accept) begin
                    stage_d = rxData;
                    xor_d   = xor_q ^ rxData;
                    state_d = S_DATA_LO;
                end
            end
            S_DATA_LO: begin
                if (accept) begin
                    mem_we  = 1'b1;
                    words_d = words_q + 16'd1;
                    xor_d   = xor_q ^ rxData;
                    state_d = (words_d == len_q) ? S_CHECK : S_DATA_HI;
                end
            end
            S_CHECK: begin
                // The checksum byte itself is compared, not folded in.
                if (accept)
                    state_d = (rxData == xor_q) ? S_RUN : S_ERROR;
            end
            S_RUN, S_ERROR: begin
                if (reload) begin
                    state_d = S_LEN_HI;
                    len_d   = '0;
                    xor_d   = '0;
                    words_d = '0;
                end
            end
            default: state_d = S_LEN_HI;
        endcase
    end

    // Status flags are registered from the next state so they change on the
    // same edge as the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_LEN_HI;
            len_q       <= '0;
            xor_q       <= '0;
            stage_q     <= '0;
            words_q     <= '0;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            xor_q       <= xor_d;
            stage_q     <= stage_d;
            words_q     <= words_d;
            cpu_reset_q <= (state_d != S_RUN);
            done_q      <= (state_d == S_RUN);
            error_q     <= (state_d == S_ERROR);
        end
    end

    // Store is not reset: old contents survive reset and short reloads.
    // Length was bounded to DEPTH, so words_q always indexes inside the store.
    always_ff @(posedge clk) begin
        if (mem_we && !reset)
            mem[words_q[ADDR_WIDTH-1:0]] <= BUS_SIZE'({stage_q, rxData});
    end

    assign IR          = (state_q == S_RUN) ? mem[PC[ADDR_WIDTH-1:0]] : '0;
    assign cpuReset    = cpu_reset_q;
    assign loadDone    = done_q;
    assign loadError   = error_q;
    assign wordsLoaded = words_q;

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rxData;
    logic        rxValid;
    logic        rxReady;
    logic        reload;
    logic [15:0] PC;
    logic [15:0] IR;
    logic        cpuReset;
    logic        loadDone;
    logic        loadError;
    logic [15:0] wordsLoaded;

    always #5 clk = ~clk;

    program_loader #(.ADDR_WIDTH(8), .BUS_SIZE(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .rxData     (rxData),
        .rxValid    (rxValid),
        .rxReady    (rxReady),
        .reload     (reload),
        .PC         (PC),
        .IR         (IR),
        .cpuReset   (cpuReset),
        .loadDone   (loadDone),
        .loadError  (loadError),
        .wordsLoaded(wordsLoaded)
    );

    int total  = 0;
    int passed = 0;

    // Reference model: image as a byte list, memory as a word array with a
    // flag for every address whose contents the bench knows.
    logic [7:0]  img[$];
    logic [15:0] mem_m[256];
    bit          known[256];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input int idle, input bit rl);
        rxValid = 1'b0;
        repeat (idle) tick();
        rxData  = b;
        rxValid = 1'b1;
        reload  = rl;
        chk("rxReady_during_load", rxReady, 1'b1);
        tick();
        rxValid = 1'b0;
        reload  = 1'b0;
    endtask

    task automatic send_image(input bit throttle, input bit rl_noise);
        foreach (img[i])
            send(img[i], throttle ? int'($urandom_range(0, 3)) : 0,
                 rl_noise && ($urandom_range(0, 5) == 0));
    endtask

    // Builds an image of n words; oversize lengths carry only the two length
    // bytes since the loader stops there.
    task automatic make_image(input int n, input bit good);
        logic [7:0] x;
        img.delete();
        img.push_back(8'(n >> 8));
        img.push_back(8'(n));
        if (n <= 256) begin
            for (int i = 0; i < 2 * n; i++) img.push_back(8'($urandom));
            x = 8'h00;
            foreach (img[i]) x ^= img[i];
            img.push_back(good ? x : (x ^ 8'($urandom_range(1, 255))));
        end
    endtask

    task automatic model_load(output bit ok, output int words);
        int n;
        logic [7:0] x;
        n = int'({img[0], img[1]});
        ok = 1'b0;
        words = 0;
        if (n > 256) return;
        for (int i = 0; i < n; i++) begin
            mem_m[i] = {img[2 + 2 * i], img[3 + 2 * i]};
            known[i] = 1'b1;
        end
        x = 8'h00;
        for (int i = 0; i < 2 + 2 * n; i++) x ^= img[i];
        ok    = (img[2 + 2 * n] == x);
        words = n;
    endtask

    task automatic check_outcome(input bit ok, input int words);
        chk("loadDone",    loadDone,    ok);
        chk("loadError",   loadError,   !ok);
        chk("cpuReset",    cpuReset,    !ok);
        chk("rxReady_end", rxReady,     1'b0);
        chk("wordsLoaded", wordsLoaded, 16'(words));
        if (ok) begin
            for (int k = 0; k < 10; k++) begin
                int a;
                a = (k == 0) ? 0 : int'($urandom_range(0, 255));
                if (known[a]) begin
                    PC = {8'($urandom), 8'(a)};
                    @(negedge clk);
                    chk("IR_fetch", IR, mem_m[a]);
                end
            end
        end else begin
            PC = 16'($urandom);
            @(negedge clk);
            chk("IR_zero_not_run", IR, 16'h0000);
        end
    endtask

    task automatic do_reload();
        reload = 1'b1;
        tick();
        reload = 1'b0;
        chk("reload_rxReady",   rxReady,     1'b1);
        chk("reload_loadError", loadError,   1'b0);
        chk("reload_loadDone",  loadDone,    1'b0);
        chk("reload_cpuReset",  cpuReset,    1'b1);
        chk("reload_words",     wordsLoaded, 16'h0000);
    endtask

    task automatic run_image(input bit throttle, input bit rl_noise);
        bit ok;
        int words;
        send_image(throttle, rl_noise);
        model_load(ok, words);
        check_outcome(ok, words);
    endtask

    initial begin
        reset   = 1'b1;
        rxData  = 8'h00;
        rxValid = 1'b0;
        reload  = 1'b0;
        PC      = 16'h0000;
        foreach (known[i]) known[i] = 1'b0;
        repeat (2) tick();
        reset = 1'b0;

        // Reset state
        chk("rst_rxReady",   rxReady,     1'b1);
        chk("rst_cpuReset",  cpuReset,    1'b1);
        chk("rst_loadDone",  loadDone,    1'b0);
        chk("rst_loadError", loadError,   1'b0);
        chk("rst_words",     wordsLoaded, 16'h0000);
        chk("rst_IR",        IR,          16'h0000);

        // Good two-word load, then explicit fetches incl. wrapped PC
        img = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
        run_image(1'b0, 1'b0);
        PC = 16'h0000; @(negedge clk); chk("IR_pc0",    IR, 16'h1234);
        PC = 16'h0101; @(negedge clk); chk("IR_pc101",  IR, 16'hABCD);

        // Bytes offered in RUN are not accepted
        rxValid = 1'b1; rxData = 8'h55;
        repeat (3) tick();
        rxValid = 1'b0;
        chk("run_hold_done",  loadDone,    1'b1);
        chk("run_hold_words", wordsLoaded, 16'd2);
        chk("run_hold_ready", rxReady,     1'b0);
        do_reload();

        // Bad checksum
        img = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h43};
        run_image(1'b0, 1'b0);
        do_reload();

        // Oversize length: error on the low length byte, no writes
        img = '{8'h01, 8'h01};
        run_image(1'b0, 1'b0);
        do_reload();

        // Zero-length image: RUN, old contents still visible
        img = '{8'h00, 8'h00, 8'h00};
        run_image(1'b0, 1'b0);
        PC = 16'h0001; @(negedge clk); chk("IR_zero_len_keep", IR, 16'hABCD);
        do_reload();

        // Throttled source, first image again
        img = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
        run_image(1'b1, 1'b0);
        do_reload();

        // Reset mid-load; reset wins over a simultaneous byte and reload
        img = '{8'h00, 8'h02, 8'h12};
        send_image(1'b0, 1'b0);
        reset = 1'b1; rxValid = 1'b1; rxData = 8'hAA; reload = 1'b1;
        tick();
        reset = 1'b0; rxValid = 1'b0; reload = 1'b0;
        chk("midrst_rxReady",  rxReady,     1'b1);
        chk("midrst_cpuReset", cpuReset,    1'b1);
        chk("midrst_words",    wordsLoaded, 16'h0000);
        chk("midrst_loadDone", loadDone,    1'b0);
        img = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
        run_image(1'b0, 1'b0);
        do_reload();

        // Randomized images: sizes incl. full depth and oversize, random
        // checksum corruption, throttling and ignored reload pulses mid-load
        for (int it = 0; it < 14; it++) begin
            int r, n;
            r = int'($urandom_range(0, 9));
            if (it == 0 || r == 0)      n = 256;
            else if (r == 1)            n = int'($urandom_range(257, 65535));
            else                        n = int'($urandom_range(0, 24));
            make_image(n, $urandom_range(0, 3) != 0);
            run_image($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
            do_reload();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
